// File: rtl/xt_plic_pkg.sv
// Shared definitions for the XT_HB external interrupt controller:
// register byte offsets and the priority field type.
package xt_plic_pkg;

  localparam int PLIC_PRIO_WIDTH = 3;

  localparam logic [7:0] PLIC_PENDING   = 8'h00;
  localparam logic [7:0] PLIC_ENABLE    = 8'h04;
  localparam logic [7:0] PLIC_THRESHOLD = 8'h08;
  localparam logic [7:0] PLIC_CLAIM     = 8'h0C;
  localparam logic [7:0] PLIC_PRIO_BASE = 8'h10;

  typedef logic [PLIC_PRIO_WIDTH-1:0] prio_t;

  // Word index of a byte offset; the bus ignores addr[1:0].
  function automatic logic [5:0] word_of(input logic [7:0] byte_addr);
    return byte_addr[7:2];
  endfunction

endpackage

// File: rtl/xt_plic_gateway.sv
// Per-source interrupt gateway: edge/level capture into pending and the
// in-service flag that gates re-triggering between claim and complete.
module xt_plic_gateway (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_irq,
  input  logic i_edge_mode,
  input  logic i_claim_hit,
  input  logic i_complete_hit,
  output logic o_pending,
  output logic o_in_service
);

  logic r_prev;
  logic r_pending;
  logic r_in_service;
  logic w_pending_nxt;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_pending_nxt = r_pending;
    if (i_edge_mode) begin
      // A fresh edge beats a simultaneous claim so it is not lost.
      if (i_irq && !r_prev) w_pending_nxt = 1'b1;
      else if (i_claim_hit) w_pending_nxt = 1'b0;
    end else begin
      if (i_claim_hit)        w_pending_nxt = 1'b0;
      else if (!r_in_service) w_pending_nxt = i_irq;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_prev       <= 1'b0;
      r_pending    <= 1'b0;
      r_in_service <= 1'b0;
    end else begin
      r_prev    <= i_irq;
      r_pending <= w_pending_nxt;
      if (i_complete_hit)   r_in_service <= 1'b0;
      else if (i_claim_hit) r_in_service <= 1'b1;
    end
  end

  assign o_pending    = r_pending;
  assign o_in_service = r_in_service;

endmodule

// File: rtl/xt_plic.sv
// XT_HB external interrupt controller: per-source priority, global threshold,
// claim/complete handshake and a registered highest-priority arbiter.
module xt_plic
  import xt_plic_pkg::*;
#(
  parameter int          INT_NUM    = 13,
  parameter int          PRIO_WIDTH = PLIC_PRIO_WIDTH,
  parameter logic [31:0] EDGE_MASK  = 32'h0000_0001
) (
  input  logic               hb_clk,
  input  logic               rst_sync,
  input  logic [INT_NUM-1:0] irq_source,
  input  logic               sel,
  input  logic               write,
  input  logic               read,
  input  logic [7:0]         addr,
  input  logic [31:0]        wdata,
  output logic [31:0]        rdata,
  output logic               mextern_int,
  output logic [30:0]        mextern_int_id
);

  localparam logic [5:0] W_PENDING   = PLIC_PENDING[7:2];
  localparam logic [5:0] W_ENABLE    = PLIC_ENABLE[7:2];
  localparam logic [5:0] W_THRESHOLD = PLIC_THRESHOLD[7:2];
  localparam logic [5:0] W_CLAIM     = PLIC_CLAIM[7:2];
  localparam logic [5:0] W_PRIO_BASE = PLIC_PRIO_BASE[7:2];

  logic [INT_NUM-1:0]    r_enable;
  logic [PRIO_WIDTH-1:0] r_threshold;
  logic [PRIO_WIDTH-1:0] r_prio [INT_NUM];
  logic [4:0]            r_id;
  logic                  r_irq;
  logic [31:0]           r_rdata;

  logic [5:0]            w_word;
  logic                  w_rd;
  logic                  w_wr;
  logic [5:0]            w_prio_idx;
  logic                  w_prio_sel;
  logic                  w_claim;
  logic [4:0]            w_cid;
  logic                  w_complete;
  logic [INT_NUM-1:0]    w_claim_hit;
  logic [INT_NUM-1:0]    w_complete_hit;
  logic [INT_NUM-1:0]    w_pending;
  logic [INT_NUM-1:0]    w_in_service;
  logic [4:0]            w_best_id;
  logic [PRIO_WIDTH-1:0] w_best_prio;
  logic [31:0]           w_rdata;
  logic                  w_unused_bits;

  assign w_word     = word_of(addr);
  assign w_wr       = sel & write;
  assign w_rd       = sel & read & ~write;
  assign w_prio_idx = w_word - W_PRIO_BASE;
  assign w_prio_sel = (w_word >= W_PRIO_BASE) && (int'(w_prio_idx) < INT_NUM);

  // A claim only has side effects when it hands out a real ID.
  assign w_claim    = w_rd && (w_word == W_CLAIM) && (r_id != 5'd0);
  assign w_cid      = wdata[4:0];
  assign w_complete = w_wr && (w_word == W_CLAIM) && (w_cid != 5'd0) && (int'(w_cid) <= INT_NUM);

  for (genvar g = 0; g < INT_NUM; g++) begin : g_src
    assign w_claim_hit[g]    = w_claim && (r_id == 5'(g + 1));
    assign w_complete_hit[g] = w_complete && (w_cid == 5'(g + 1));

    xt_plic_gateway u_gateway (
      .i_clk          (hb_clk),
      .i_rst          (rst_sync),
      .i_irq          (irq_source[g]),
      .i_edge_mode    (EDGE_MASK[g]),
      .i_claim_hit    (w_claim_hit[g]),
      .i_complete_hit (w_complete_hit[g]),
      .o_pending      (w_pending[g]),
      .o_in_service   (w_in_service[g])
    );
  end

  // Ascending scan with strict compare: equal priorities keep the lowest ID.
  always_comb begin
    w_best_id   = 5'd0;
    w_best_prio = '0;
    for (int k = 0; k < INT_NUM; k++) begin
      if (w_pending[k] && r_enable[k] && !w_in_service[k] &&
          (r_prio[k] > r_threshold) && (r_prio[k] > w_best_prio)) begin
        w_best_prio = r_prio[k];
        w_best_id   = 5'(k + 1);
      end
    end
  end

  always_comb begin
    w_rdata = '0;
    case (w_word)
      W_PENDING:   w_rdata[INT_NUM-1:0]    = w_pending;
      W_ENABLE:    w_rdata[INT_NUM-1:0]    = r_enable;
      W_THRESHOLD: w_rdata[PRIO_WIDTH-1:0] = r_threshold;
      W_CLAIM:     w_rdata[4:0]            = r_id;
      default: begin
        for (int k = 0; k < INT_NUM; k++) begin
          if (w_prio_sel && (w_prio_idx == 6'(k))) w_rdata[PRIO_WIDTH-1:0] = r_prio[k];
        end
      end
    endcase
  end

  always_ff @(posedge hb_clk) begin
    if (rst_sync) begin
      r_enable    <= '0;
      r_threshold <= '0;
      // NOTE: the priority array is a handful of flops, not a RAM, so it is cleared with the rest.
      for (int k = 0; k < INT_NUM; k++) r_prio[k] <= '0;
      r_id        <= 5'd0;
      r_irq       <= 1'b0;
      r_rdata     <= '0;
    end else begin
      if (w_wr && (w_word == W_ENABLE))    r_enable    <= wdata[INT_NUM-1:0];
      if (w_wr && (w_word == W_THRESHOLD)) r_threshold <= wdata[PRIO_WIDTH-1:0];
      for (int k = 0; k < INT_NUM; k++) begin
        if (w_wr && w_prio_sel && (w_prio_idx == 6'(k))) r_prio[k] <= wdata[PRIO_WIDTH-1:0];
      end
      if (w_rd) r_rdata <= w_rdata;
      r_id  <= w_best_id;
      r_irq <= (w_best_id != 5'd0);
    end
  end

  assign w_unused_bits  = ^{addr[1:0], wdata};
  assign rdata          = r_rdata;
  assign mextern_int    = r_irq;
  assign mextern_int_id = 31'(r_id);

endmodule

// File: tb/tb_xt_plic.sv
// Scoreboard bench for xt_plic: directed scenarios then random traffic, all
// checked against a cycle-level behavioural model of the controller.
module tb_xt_plic;
  import xt_plic_pkg::*;

  localparam int          N    = 13;
  localparam logic [31:0] EDGE = 32'h0000_0081;

  logic         hb_clk = 1'b0;
  logic         rst_sync = 1'b1;
  logic [N-1:0] irq_source = '0;
  logic         sel = 1'b0, write = 1'b0, read = 1'b0;
  logic [7:0]   addr = '0;
  logic [31:0]  wdata = '0;
  logic [31:0]  rdata;
  logic         mextern_int;
  logic [30:0]  mextern_int_id;

  xt_plic #(.INT_NUM(N), .PRIO_WIDTH(PLIC_PRIO_WIDTH), .EDGE_MASK(EDGE)) dut (
    .hb_clk(hb_clk), .rst_sync(rst_sync), .irq_source(irq_source),
    .sel(sel), .write(write), .read(read), .addr(addr), .wdata(wdata),
    .rdata(rdata), .mextern_int(mextern_int), .mextern_int_id(mextern_int_id)
  );

  always #5 hb_clk = ~hb_clk;

  int n_total = 0;
  int n_bad   = 0;
  bit mon_en  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: per-source pending/in-service bits, registers, and
  // the registered winner, stepped once per clock edge.
  bit [N-1:0]  m_pend, m_isv, m_prev, m_en;
  prio_t       m_thr;
  prio_t       m_prio [N];
  int          m_id;
  bit          m_int;
  logic [31:0] exp_q [$];
  logic [31:0] e_rd;

  function automatic logic [31:0] model_read(input logic [7:0] a);
    int w = int'(a[7:2]);
    if (w == 0) return 32'(m_pend);
    if (w == 1) return 32'(m_en);
    if (w == 2) return 32'(m_thr);
    if (w == 3) return 32'(m_id);
    if (w >= 4 && w < 4 + N) return 32'(m_prio[w-4]);
    return 32'd0;
  endfunction

  task automatic model_step();
    int w, nid, bp, cl, cp;
    bit rd, wr;
    bit [N-1:0] np, ni;
    if (rst_sync) begin
      m_pend = '0; m_isv = '0; m_prev = '0; m_en = '0; m_thr = '0;
      for (int k = 0; k < N; k++) m_prio[k] = '0;
      m_id = 0; m_int = 1'b0;
      return;
    end
    rd = sel && read && !write;
    wr = sel && write;
    w  = int'(addr[7:2]);
    if (rd) exp_q.push_back(model_read(addr));
    nid = 0; bp = 0;
    for (int k = 0; k < N; k++)
      if (m_pend[k] && m_en[k] && !m_isv[k] && int'(m_prio[k]) > int'(m_thr) && int'(m_prio[k]) > bp) begin
        bp  = int'(m_prio[k]);
        nid = k + 1;
      end
    cl = (rd && w == 3 && m_id != 0) ? m_id - 1 : -1;
    cp = (wr && w == 3 && wdata[4:0] >= 5'd1 && int'(wdata[4:0]) <= N) ? int'(wdata[4:0]) - 1 : -1;
    for (int k = 0; k < N; k++) begin
      ni[k] = m_isv[k];
      if (k == cp) ni[k] = 1'b0;
      if (k == cl) ni[k] = 1'b1;
      if (EDGE[k]) np[k] = (irq_source[k] && !m_prev[k]) ? 1'b1 : ((k == cl) ? 1'b0 : m_pend[k]);
      else         np[k] = (k == cl) ? 1'b0 : (m_isv[k] ? m_pend[k] : irq_source[k]);
    end
    if (wr && w == 1) m_en = wdata[N-1:0];
    if (wr && w == 2) m_thr = prio_t'(wdata);
    if (wr && w >= 4 && w < 4 + N) m_prio[w-4] = prio_t'(wdata);
    m_pend = np; m_isv = ni; m_prev = irq_source;
    m_id = nid; m_int = (nid != 0);
  endtask

  always @(posedge hb_clk) model_step();

  // Monitor: outputs are compared every cycle; read data whenever a read is owed.
  always @(negedge hb_clk) begin
    if (mon_en) begin
      check("mextern_int", 32'(mextern_int), 32'(m_int));
      check("mextern_int_id", 32'(mextern_int_id), 32'(m_id));
      if (exp_q.size() != 0) begin
        e_rd = exp_q.pop_front();
        check("rdata", rdata, e_rd);
      end
    end
  end

  task automatic tick();
    @(posedge hb_clk);
    #1;
  endtask

  task automatic bus_write(input logic [7:0] a, input logic [31:0] d);
    sel = 1'b1; write = 1'b1; addr = a; wdata = d;
    tick();
    sel = 1'b0; write = 1'b0;
  endtask

  task automatic bus_read(input logic [7:0] a);
    sel = 1'b1; read = 1'b1; addr = a;
    tick();
    sel = 1'b0; read = 1'b0;
  endtask

  task automatic pulse(input int k);
    irq_source[k] = 1'b1;
    tick();
    irq_source[k] = 1'b0;
  endtask

  initial begin
    int r;
    repeat (3) tick();
    rst_sync = 1'b0;
    mon_en   = 1'b1;

    // Reset then idle: every register, plus unmapped words, reads 0.
    for (int a = 0; a <= 8'h44; a += 4) bus_read(8'(a));
    bus_read(8'h80);
    bus_read(8'hFC);
    check("idle_int", 32'(mextern_int), 32'd0);

    // Basic claim on edge source 0.
    bus_write(PLIC_ENABLE, 32'h1);
    bus_write(PLIC_PRIO_BASE, 32'd3);
    bus_write(PLIC_THRESHOLD, 32'd0);
    pulse(0);
    tick();
    check("basic_int", 32'(mextern_int), 32'd1);
    check("basic_id", 32'(mextern_int_id), 32'd1);
    bus_read(PLIC_CLAIM);
    check("basic_claim", rdata, 32'd1);
    tick(); tick();
    check("basic_drop", 32'(mextern_int), 32'd0);
    bus_read(PLIC_PENDING);
    check("basic_pending", rdata, 32'd0);
    bus_write(PLIC_CLAIM, 32'd1);

    // Priority arbitration among level sources 2 and 5.
    bus_write(PLIC_ENABLE, 32'h24);
    bus_write(8'h18, 32'd2);
    bus_write(8'h24, 32'd6);
    irq_source[2] = 1'b1; irq_source[5] = 1'b1;
    repeat (3) tick();
    check("arb_high", 32'(mextern_int_id), 32'd6);
    bus_write(8'h24, 32'd2);
    tick(); tick();
    check("arb_tie", 32'(mextern_int_id), 32'd3);
    bus_write(PLIC_THRESHOLD, 32'd2);
    tick(); tick();
    check("arb_thresh", 32'(mextern_int), 32'd0);
    irq_source[2] = 1'b0; irq_source[5] = 1'b0;
    bus_write(PLIC_THRESHOLD, 32'd0);

    // Level source 3: re-pends after complete while held, not after dropping.
    bus_write(PLIC_ENABLE, 32'h8);
    bus_write(8'h1C, 32'd5);
    irq_source[3] = 1'b1;
    repeat (3) tick();
    check("level_id", 32'(mextern_int_id), 32'd4);
    bus_read(PLIC_CLAIM);
    check("level_claim", rdata, 32'd4);
    repeat (3) tick();
    check("level_in_service", 32'(mextern_int), 32'd0);
    bus_write(PLIC_CLAIM, 32'd4);
    tick(); tick();
    check("level_repend", 32'(mextern_int_id), 32'd4);
    bus_read(PLIC_CLAIM);
    irq_source[3] = 1'b0;
    tick();
    bus_write(PLIC_CLAIM, 32'd4);
    repeat (4) tick();
    check("level_no_repend", 32'(mextern_int), 32'd0);

    // Edge on source 0 while it is in service.
    bus_write(PLIC_ENABLE, 32'h1);
    pulse(0);
    tick();
    bus_read(PLIC_CLAIM);
    pulse(0);
    repeat (3) tick();
    bus_read(PLIC_PENDING);
    check("edge_pend_in_service", rdata, 32'h1);
    check("edge_masked", 32'(mextern_int), 32'd0);
    bus_write(PLIC_CLAIM, 32'd1);
    tick(); tick();
    check("edge_reassert", 32'(mextern_int_id), 32'd1);

    // Bogus complete, then reset while in service.
    bus_read(PLIC_CLAIM);
    bus_write(PLIC_CLAIM, 32'd9);
    pulse(0);
    repeat (3) tick();
    check("bogus_complete", 32'(mextern_int), 32'd0);
    rst_sync = 1'b1;
    tick(); tick();
    rst_sync = 1'b0;
    bus_write(PLIC_ENABLE, 32'h1);
    bus_write(PLIC_PRIO_BASE, 32'd3);
    repeat (3) tick();
    check("post_reset_quiet", 32'(mextern_int), 32'd0);
    bus_read(PLIC_PENDING);
    check("post_reset_pending", rdata, 32'd0);

    // Random traffic against the model.
    bus_write(PLIC_ENABLE, 32'h1FFF);
    for (int k = 0; k < N; k++) bus_write(8'(PLIC_PRIO_BASE + 8'(4 * k)), $urandom_range(0, 7));
    for (int i = 0; i < 1500; i++) begin
      for (int k = 0; k < N; k++)
        if ($urandom_range(0, 7) == 0) irq_source[k] = ~irq_source[k];
      r = $urandom_range(0, 15);
      if (r <= 5)       tick();
      else if (r == 6)  bus_write(PLIC_ENABLE, $urandom | 32'h0000_1F0F);
      else if (r == 7)  bus_write(PLIC_THRESHOLD, $urandom_range(0, 3));
      else if (r == 8)  bus_write(8'(PLIC_PRIO_BASE + 8'(4 * $urandom_range(0, N - 1))), $urandom);
      else if (r <= 11) bus_read(PLIC_CLAIM);
      else if (r <= 13) bus_write(PLIC_CLAIM, $urandom_range(0, 15));
      else if (r == 14) bus_write(8'($urandom_range(0, 255)), $urandom);
      else              bus_read(8'($urandom_range(0, 255)));
    end

    irq_source = '0;
    repeat (3) tick();
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    mon_en = 1'b0;
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/xt_plic.md
Name: xt_plic

Overview:
- Parametrised external interrupt controller for the XT_HB local domain.
- Generalises the fixed 13-source controller with:
  - per-source priority, global threshold and edge/level mode;
  - a claim/complete handshake;
  - a registered arbitration pipeline.
- Drives the core's mextern_int and mextern_int_id. Sources arrive as the irq_source vector (UART, I2C, SPI, timer, UFM, and later additions).

Parameters:
- INT_NUM, 13, number of sources (1..31); source k has ID k+1, and ID 0 means "none".
- PRIO_WIDTH, 3, priority bits per source; priority 0 means never interrupt.
- EDGE_MASK, 32'h0000_0001, bit k=1 makes source k rising-edge triggered; otherwise it is level-triggered.

Ports:
- hb_clk  input  1  bus and core clock
- rst_sync  input  1  synchronous, active-high reset
- irq_source  input  INT_NUM  raw requests, synchronous to hb_clk
- sel  input  1  slave selected this cycle
- write  input  1  write strobe (valid with sel)
- read  input  1  read strobe (valid with sel)
- addr  input  8  byte address; addr[1:0] ignored
- wdata  input  32  write data
- rdata  output  32  read data, valid the cycle after the read
- mextern_int  output  1  external interrupt request to core
- mextern_int_id  output  31  ID of the current best claimable source, 0 if none

Behaviour:
- Reset (rst_sync=1 at an hb_clk edge) clears all state to 0: pending, in_service, enable, threshold, all priorities, edge history, rdata, mextern_int, mextern_int_id.
- Gateway, per source k:
  - Edge mode: prev_k is registered each cycle; irq & !prev sets pending_k on the next edge.
  - Level mode: irq=1 sets pending_k while in_service_k=0. irq dropping clears pending_k if the source is not in service.
  - Edge mode: an edge during in_service is latched into pending_k. It becomes claimable after complete.
- claimable_k = pending_k & enable_k & !in_service_k & (prio_k > threshold).
- Arbitration:
  - Highest priority wins; ties go to the lowest ID.
  - The result is registered, so mextern_int_id and mextern_int = (id != 0) update one cycle after pending, enable, priority or threshold change.
  - Trigger at cycle N → pending at N+1 → mextern_int at N+2.
- Register map, word aligned:
  - 0x00: pending, read-only, bit k.
  - 0x04: enable, read/write, INT_NUM bits.
  - 0x08: threshold, read/write, PRIO_WIDTH bits.
  - 0x0C: claim/complete.
  - 0x10+4k: priority of source k, read/write.
  - Unmapped reads return 0 and unmapped writes are ignored. Unused high bits read 0.
- Claim (read 0x0C):
  - Returns the registered mextern_int_id.
  - If it is nonzero, pending is cleared and in_service is set for that source on the same edge.
  - mextern_int drops at the earliest on the second edge after the claim.
  - A claim that returns 0 has no side effects.
- Simultaneous claim and a new edge on the same source: the set wins, so pending stays 1 and in_service is set.
- Complete (write 0x0C with wdata[4:0]=ID):
  - Clears in_service for that ID.
  - A complete with ID 0, ID > INT_NUM, or a non-in-service ID is ignored.
  - A level source still asserted re-pends on the next cycle.
- Read and write in the same cycle are not supported; write takes precedence.
- Single-cycle access, no wait states. rdata holds its value until the next read.
- Reset mid-service drops all in_service and pending bits; there is no residual interrupt.

Decomposition:
- Shared package (XT_BUS or a new XT_PLIC_PKG) holds:
  - register offsets: PLIC_PENDING, PLIC_ENABLE, PLIC_THRESHOLD, PLIC_CLAIM, PLIC_PRIO_BASE;
  - the prio_t typedef (logic [PRIO_WIDTH-1:0]).
- One sub-module: xt_plic_gateway.
  - One instance per source via generate.
  - Holds prev, pending and in_service.
  - Inputs: irq, edge_mode, claim_hit, complete_hit. Output: pending.

Test Plan:
- Reset then idle:
  - Stimulus: after reset, read all registers.
  - Response: every register reads 0; mextern_int=0.
- Basic claim:
  - Stimulus: enable=0x1, prio0=3, threshold=0; pulse irq_source[0] at cycle N.
  - Response: mextern_int=1 and id=1 at N+2.
  - Response: claim read returns 1; pending=0; mextern_int=0 two cycles later.
- Priority arbitration:
  - Stimulus: sources 2 and 5 level-high, prio2=2, prio5=6.
  - Response: id=6.
  - Then set prio5=2. Response: id=3 (tie, lowest ID).
  - Then set threshold=2. Response: mextern_int=0.
- Level re-pend after complete:
  - Stimulus: hold source 3 high, claim (returns 4), then complete with 4.
  - Response: re-asserts with id=4 two cycles after the complete.
  - Stimulus: drop source 3 before the complete.
  - Response: no re-assert.
- Edge during service:
  - Stimulus: claim edge source 0, pulse again while in service.
  - Response: pending[0]=1 but mextern_int=0.
  - Stimulus: complete with 1.
  - Response: id=1 re-asserts.
- Bogus complete and reset mid-service:
  - Stimulus: complete with 9 while 1 is in service.
  - Response: ignored.
  - Stimulus: assert rst_sync.
  - Response: all state 0; no interrupt after release while irqs are low.
